// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding and default frame timing for the pong match controller
package pong_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int SCORE_W_D      = 4;
    localparam int WIN_SCORE_D    = 9;
    localparam int SERVE_FRAMES_D = 60;
    localparam int POINT_FRAMES_D = 30;
    localparam int OVER_FRAMES_D  = 180;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - signal bundle between the pong datapath side and the match controller
interface pong_game_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               vsync;
    logic               start;
    logic               miss_left;
    logic               miss_right;
    logic               ball_run;
    logic               ball_centre;
    logic               serve_dir;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic               game_over;
    logic               winner;
    logic [2:0]         state;

    modport master (
        output vsync, start, miss_left, miss_right,
        input  ball_run, ball_centre, serve_dir, score1, score2, game_over, winner, state
    );

    modport slave (
        input  vsync, start, miss_left, miss_right,
        output ball_run, ball_centre, serve_dir, score1, score2, game_over, winner, state
    );
endinterface

// File: rtl/pong_frame_timer.sv
// rtl/pong_frame_timer.sv - vsync rising-edge tick and clearable frame counter with done at the last frame
module pong_frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vsync,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_last,
    output logic             o_tick,
    output logic             o_done
);
    logic             r_vsync_q;
    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_vsync & ~r_vsync_q;
    assign o_done = o_tick & (r_cnt == i_last);

    // vsync delay for edge detect; counter restarts on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_q <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_vsync_q <= i_vsync;
            if (i_clear)
                r_cnt <= '0;
            else if (o_tick)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong match FSM, scores and ball gating; PONG_ATTRACT_EN enables an attract demo in IDLE
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_W      = SCORE_W_D,
    parameter int WIN_SCORE    = WIN_SCORE_D,
    parameter int SERVE_FRAMES = SERVE_FRAMES_D,
    parameter int POINT_FRAMES = POINT_FRAMES_D,
    parameter int OVER_FRAMES  = OVER_FRAMES_D
) (
    input logic clk,
    input logic rst_n,
    pong_game_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(max3(SERVE_FRAMES, POINT_FRAMES, OVER_FRAMES) + 1);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [CNT_W-1:0]   OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    state_t             r_state, w_nxt;
    logic [SCORE_W-1:0] r_score1, r_score2, w_score1, w_score2;
    logic               r_serve_dir, w_serve_dir;
    logic               r_winner, w_winner;
    logic               r_over_ok, w_over_ok;
    logic               r_ball_run, r_ball_centre, r_game_over;
    logic               w_ball_run, w_ball_centre, w_game_over;
    logic               w_clear, w_tick, w_done;
    logic [CNT_W-1:0]   w_last;

    pong_frame_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vsync (bus.vsync),
        .i_clear (w_clear),
        .i_last  (w_last),
        .o_tick  (w_tick),
        .o_done  (w_done)
    );

    // frame count that ends the current timed state
    always_comb begin
        w_last = '0;
        case (r_state)
            ST_SERVE: w_last = SERVE_LAST;
            ST_POINT: w_last = POINT_LAST;
            ST_OVER:  w_last = OVER_LAST;
            default:  w_last = '0;
        endcase
    end

    // next state, next scores and next Moore outputs derived from the next state
    always_comb begin
        w_nxt       = r_state;
        w_score1    = r_score1;
        w_score2    = r_score2;
        w_serve_dir = r_serve_dir;
        w_winner    = r_winner;
        w_over_ok   = r_over_ok;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_nxt       = ST_SERVE;
                    w_score1    = '0;
                    w_score2    = '0;
                    w_serve_dir = 1'b1;
                end
`ifdef PONG_ATTRACT_EN
                else if (bus.miss_left | bus.miss_right) begin
                    w_serve_dir = ~r_serve_dir;
                end
`endif
            end
            ST_SERVE: begin
                if (w_done) w_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                // simultaneous misses are a replay: no score, direction kept
                if (bus.miss_left && bus.miss_right) begin
                    w_nxt = ST_POINT;
                end else if (bus.miss_left) begin
                    w_nxt       = ST_POINT;
                    w_score2    = r_score2 + SCORE_W'(1);
                    w_serve_dir = 1'b0;
                end else if (bus.miss_right) begin
                    w_nxt       = ST_POINT;
                    w_score1    = r_score1 + SCORE_W'(1);
                    w_serve_dir = 1'b1;
                end
            end
            ST_POINT: begin
                if (w_done) begin
                    if (r_score1 == WIN_VAL || r_score2 == WIN_VAL) begin
                        w_nxt    = ST_OVER;
                        w_winner = (r_score2 == WIN_VAL);
                    end else begin
                        w_nxt = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (w_done) w_over_ok = 1'b1;
                if (bus.start && (r_over_ok || w_done)) begin
                    w_nxt       = ST_SERVE;
                    w_score1    = '0;
                    w_score2    = '0;
                    w_serve_dir = 1'b1;
                end
            end
            default: w_nxt = ST_IDLE;
        endcase

        if (w_nxt != r_state) w_over_ok = 1'b0;
        w_clear = (w_nxt != r_state);

        w_game_over = (w_nxt == ST_OVER);
`ifdef PONG_ATTRACT_EN
        w_ball_run    = (w_nxt == ST_PLAY) || (w_nxt == ST_IDLE);
        w_ball_centre = (w_nxt == ST_SERVE) || (w_nxt == ST_OVER);
`else
        w_ball_run    = (w_nxt == ST_PLAY);
        w_ball_centre = (w_nxt == ST_IDLE) || (w_nxt == ST_SERVE) || (w_nxt == ST_OVER);
`endif
    end

    // state, score and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_score1      <= '0;
            r_score2      <= '0;
            r_serve_dir   <= 1'b1;
            r_winner      <= 1'b0;
            r_over_ok     <= 1'b0;
            r_ball_run    <= 1'b0;
            r_ball_centre <= 1'b1;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_nxt;
            r_score1      <= w_score1;
            r_score2      <= w_score2;
            r_serve_dir   <= w_serve_dir;
            r_winner      <= w_winner;
            r_over_ok     <= w_over_ok;
            r_ball_run    <= w_ball_run;
            r_ball_centre <= w_ball_centre;
            r_game_over   <= w_game_over;
        end
    end

    assign bus.state       = r_state;
    assign bus.score1      = r_score1;
    assign bus.score2      = r_score2;
    assign bus.serve_dir   = r_serve_dir;
    assign bus.winner      = r_winner;
    assign bus.ball_run    = r_ball_run;
    assign bus.ball_centre = r_ball_centre;
    assign bus.game_over   = r_game_over;

    logic w_unused;
    assign w_unused = w_tick;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed self-checking bench for pong_game_ctrl
module tb_pong_game_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pong_game_ctrl_if #(.SCORE_W(4)) bus ();

    pong_game_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.vsync = 1'b1;
            repeat (2) @(negedge clk);
            bus.vsync = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        bus.miss_left  = l;
        bus.miss_right = r;
        @(negedge clk);
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        total++; if (bus.score1 !== 4'd0 || bus.score2 !== 4'd0) begin bad++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", bus.score1, bus.score2); end
        total++; if (bus.ball_run !== 1'b0 || bus.ball_centre !== 1'b1) begin bad++; $display("FAIL reset_ball got=run%b/ctr%b exp=run0/ctr1", bus.ball_run, bus.ball_centre); end
        total++; if (bus.serve_dir !== 1'b1 || bus.game_over !== 1'b0 || bus.winner !== 1'b0) begin bad++; $display("FAIL reset_flags got=dir%b/go%b/win%b exp=1/0/0", bus.serve_dir, bus.game_over, bus.winner); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_miss();
        pulse_miss(1'b1, 1'b0);
        @(negedge clk);
        total++; if (bus.state !== 3'd0 || bus.score2 !== 4'd0) begin bad++; $display("FAIL idle_miss_state got=st%0d/s2=%0d exp=st0/s2=0", bus.state, bus.score2); end
`ifdef PONG_ATTRACT_EN
        total++; if (bus.serve_dir !== 1'b0 || bus.ball_run !== 1'b1 || bus.ball_centre !== 1'b0) begin bad++; $display("FAIL idle_attract got=dir%b/run%b/ctr%b exp=0/1/0", bus.serve_dir, bus.ball_run, bus.ball_centre); end
`else
        total++; if (bus.serve_dir !== 1'b1 || bus.ball_run !== 1'b0 || bus.ball_centre !== 1'b1) begin bad++; $display("FAIL idle_hold got=dir%b/run%b/ctr%b exp=1/0/1", bus.serve_dir, bus.ball_run, bus.ball_centre); end
`endif
    endtask

    task automatic test_serve();
        pulse_start();
        total++; if (bus.state !== 3'd1 || bus.score1 !== 4'd0 || bus.score2 !== 4'd0) begin bad++; $display("FAIL serve_entry got=st%0d/%0d/%0d exp=st1/0/0", bus.state, bus.score1, bus.score2); end
        total++; if (bus.ball_centre !== 1'b1 || bus.ball_run !== 1'b0 || bus.serve_dir !== 1'b1) begin bad++; $display("FAIL serve_ball got=ctr%b/run%b/dir%b exp=1/0/1", bus.ball_centre, bus.ball_run, bus.serve_dir); end
        frames(10);
        pulse_miss(1'b0, 1'b1);
        total++; if (bus.score1 !== 4'd0 || bus.state !== 3'd1) begin bad++; $display("FAIL serve_miss_ignored got=s1=%0d/st%0d exp=0/1", bus.score1, bus.state); end
        frames(49);
        total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL serve_59 got=%0d exp=1", bus.state); end
        frames(1);
        total++; if (bus.state !== 3'd2 || bus.ball_run !== 1'b1 || bus.ball_centre !== 1'b0) begin bad++; $display("FAIL play_entry got=st%0d/run%b/ctr%b exp=2/1/0", bus.state, bus.ball_run, bus.ball_centre); end
    endtask

    task automatic test_point_right();
        pulse_miss(1'b0, 1'b1);
        total++; if (bus.score1 !== 4'd1 || bus.serve_dir !== 1'b1 || bus.state !== 3'd3) begin bad++; $display("FAIL point_right got=s1=%0d/dir%b/st%0d exp=1/1/3", bus.score1, bus.serve_dir, bus.state); end
        total++; if (bus.ball_run !== 1'b0 || bus.ball_centre !== 1'b0) begin bad++; $display("FAIL point_ball got=run%b/ctr%b exp=0/0", bus.ball_run, bus.ball_centre); end
        pulse_miss(1'b1, 1'b0);
        total++; if (bus.score2 !== 4'd0) begin bad++; $display("FAIL point_miss_ignored got=%0d exp=0", bus.score2); end
        frames(29);
        total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL point_29 got=%0d exp=3", bus.state); end
        frames(1);
        total++; if (bus.state !== 3'd1 || bus.ball_centre !== 1'b1) begin bad++; $display("FAIL point_to_serve got=st%0d/ctr%b exp=1/1", bus.state, bus.ball_centre); end
        frames(60);
    endtask

    task automatic test_both_miss();
        pulse_miss(1'b1, 1'b1);
        total++; if (bus.score1 !== 4'd1 || bus.score2 !== 4'd0 || bus.serve_dir !== 1'b1 || bus.state !== 3'd3) begin bad++; $display("FAIL both_miss got=%0d/%0d/dir%b/st%0d exp=1/0/1/3", bus.score1, bus.score2, bus.serve_dir, bus.state); end
        frames(90);
    endtask

    task automatic test_win();
        for (int i = 1; i <= 9; i++) begin
            pulse_miss(1'b1, 1'b0);
            total++; if (bus.score2 !== 4'(i) || bus.serve_dir !== 1'b0 || bus.state !== 3'd3) begin bad++; $display("FAIL win_step%0d got=s2=%0d/dir%b/st%0d exp=%0d/0/3", i, bus.score2, bus.serve_dir, bus.state, i); end
            frames(30);
            if (i < 9) frames(60);
        end
        total++; if (bus.state !== 3'd4 || bus.game_over !== 1'b1 || bus.winner !== 1'b1) begin bad++; $display("FAIL gameover got=st%0d/go%b/win%b exp=4/1/1", bus.state, bus.game_over, bus.winner); end
        total++; if (bus.ball_centre !== 1'b1 || bus.ball_run !== 1'b0 || bus.score2 !== 4'd9 || bus.score1 !== 4'd1) begin bad++; $display("FAIL gameover_hold got=ctr%b/run%b/%0d/%0d exp=1/0/1/9", bus.ball_centre, bus.ball_run, bus.score1, bus.score2); end
        frames(100);
        pulse_start();
        total++; if (bus.state !== 3'd4) begin bad++; $display("FAIL early_start got=%0d exp=4", bus.state); end
        frames(79);
        pulse_start();
        total++; if (bus.state !== 3'd4) begin bad++; $display("FAIL start_179 got=%0d exp=4", bus.state); end
        frames(1);
        total++; if (bus.state !== 3'd4 || bus.winner !== 1'b1) begin bad++; $display("FAIL over_180_wait got=st%0d/win%b exp=4/1", bus.state, bus.winner); end
        pulse_start();
        total++; if (bus.state !== 3'd1 || bus.score1 !== 4'd0 || bus.score2 !== 4'd0 || bus.serve_dir !== 1'b1 || bus.game_over !== 1'b0) begin bad++; $display("FAIL restart got=st%0d/%0d/%0d/dir%b/go%b exp=1/0/0/1/0", bus.state, bus.score1, bus.score2, bus.serve_dir, bus.game_over); end
    endtask

    task automatic test_async_reset();
        frames(60);
        pulse_miss(1'b1, 1'b0);
        frames(90);
        total++; if (bus.state !== 3'd2 || bus.score2 !== 4'd1) begin bad++; $display("FAIL pre_reset got=st%0d/s2=%0d exp=2/1", bus.state, bus.score2); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.state !== 3'd0 || bus.score2 !== 4'd0 || bus.ball_run !== 1'b0 || bus.ball_centre !== 1'b1 || bus.serve_dir !== 1'b1) begin bad++; $display("FAIL async_reset got=st%0d/s2=%0d/run%b/ctr%b/dir%b exp=0/0/0/1/1", bus.state, bus.score2, bus.ball_run, bus.ball_centre, bus.serve_dir); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus.vsync = 1'b0;
        bus.start = 1'b0;
        bus.miss_left = 1'b0;
        bus.miss_right = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle_miss();
        test_serve();
        test_point_right();
        test_both_miss();
        test_win();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
